// File: rtl/softmax_rr_arbiter.sv
// Purpose: round-robin share of one 4-lane softmax core between two requesters, with a done-watchdog.
// Latency: accept at A, core_start at A+1, rsp_valid from A+4 with a 2-cycle core; 5 cycles/op minimum.
// Backpressure: a response is held until the granted requester takes it; no new accept until then.
module softmax_rr_arbiter #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*4*WIDTH-1:0] req_x,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [4*WIDTH-1:0]   rsp_y,
  output logic                 core_start,
  output logic [4*WIDTH-1:0]   core_x,
  input  logic [4*WIDTH-1:0]   core_y,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int VW   = 4 * WIDTH;
  localparam int WD_W = $clog2(TIMEOUT);

  // Elaboration-time sanity checks on the parameter set.
  if (TIMEOUT < 3) begin : g_bad_timeout
    $error("softmax_rr_arbiter: TIMEOUT must be >= 3");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("softmax_rr_arbiter: FRAC_WIDTH must not exceed WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic            gnt;
  logic            sel;
  logic            wd_expired;
  logic [WD_W-1:0] wd_cnt;
  logic [VW-1:0]   x_reg;
  logic [VW-1:0]   y_reg;

  // The requester that did not win last time has priority; otherwise the only valid one wins.
  assign sel        = req_valid[~last_grant] ? ~last_grant : last_grant;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

  assign core_x = x_reg;
  assign rsp_y  = y_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a late or stray core_done outside WAIT is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (core_done)       state_nxt = RESP;
        else if (wd_expired) state_nxt = IDLE;
      end
      RESP:    if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; req_ready is masked during reset so nothing looks accepted while the block is being cleared.
  always_comb begin
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    core_start  = 1'b0;
    err_timeout = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (!rst && (|req_valid)) req_ready[sel] = 1'b1;
      ISSUE:   core_start = 1'b1;
      WAIT:    err_timeout = !core_done && wd_expired;
      RESP:    rsp_valid[gnt] = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, result capture on done, watchdog count, arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      wd_cnt     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            x_reg <= sel ? req_x[VW +: VW] : req_x[0 +: VW];
            gnt   <= sel;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          if (core_done)       y_reg      <= core_y;
          else if (wd_expired) last_grant <= gnt;
          else                 wd_cnt     <= wd_cnt + WD_W'(1);
        end
        RESP: begin
          if (rsp_ready[gnt]) last_grant <= gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_rr_arbiter.sv
// Bench for softmax_rr_arbiter: table-driven cycle vectors plus directed multi-cycle sequences.
// A behavioural 2-cycle core answers core_start with core_x XOR a fixed mask.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_softmax_rr_arbiter;

  localparam int W  = 32;
  localparam int VW = 4 * W;
  localparam logic [VW-1:0] MASK = 128'hA5A5_0000_5A5A_0000_0F0F_F0F0_1234_5678;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*VW-1:0] req_x;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [VW-1:0]   rsp_y;
  logic            core_start;
  logic [VW-1:0]   core_x;
  logic [VW-1:0]   core_y;
  logic            core_done;
  logic            busy;
  logic            err_timeout;

  logic [VW-1:0]   xv [2];
  logic            core_en;
  int              core_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign req_x = {xv[1], xv[0]};

  softmax_rr_arbiter #(.WIDTH(32), .FRAC_WIDTH(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .core_start (core_start),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_done  (core_done),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  // Core model: done one cycle wide, two cycles after the start cycle.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (rst) begin
      core_cnt = 0;
    end else begin
      if (core_cnt != 0) begin
        core_cnt = core_cnt - 1;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_y    = core_x ^ MASK;
        end
      end
      if (core_start && core_en) core_cnt = 2;
    end
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] rv, input logic [1:0] rr);
    @(negedge clk);
    req_valid = rv;
    rsp_ready = rr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".req_ready"},  VW'(req_ready),   '0);
    chk({tag, ".rsp_valid"},  VW'(rsp_valid),   '0);
    chk({tag, ".core_start"}, VW'(core_start),  '0);
    chk({tag, ".busy"},       VW'(busy),        '0);
    chk({tag, ".err"},        VW'(err_timeout), '0);
    chk({tag, ".core_x"},     core_x,           '0);
    chk({tag, ".rsp_y"},      rsp_y,            '0);
  endtask

  typedef struct {
    logic [1:0] rv;
    logic [1:0] rr;
    logic [1:0] e_rdy;
    logic       e_start;
    logic [1:0] e_rsp;
    logic       e_busy;
    logic       g;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] rr, input logic [1:0] e_rdy,
                              input logic e_start, input logic [1:0] e_rsp, input logic e_busy,
                              input logic g);
    vec_t v;
    v.rv = rv; v.rr = rr; v.e_rdy = e_rdy; v.e_start = e_start;
    v.e_rsp = e_rsp; v.e_busy = e_busy; v.g = g;
    return v;
  endfunction

  task automatic run_rows(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].rv, tbl[i].rr);
      chk($sformatf("%s[%0d].req_ready", tag, i),  VW'(req_ready),   VW'(tbl[i].e_rdy));
      chk($sformatf("%s[%0d].core_start", tag, i), VW'(core_start),  VW'(tbl[i].e_start));
      chk($sformatf("%s[%0d].rsp_valid", tag, i),  VW'(rsp_valid),   VW'(tbl[i].e_rsp));
      chk($sformatf("%s[%0d].busy", tag, i),       VW'(busy),        VW'(tbl[i].e_busy));
      chk($sformatf("%s[%0d].err", tag, i),        VW'(err_timeout), '0);
      if (tbl[i].e_start) chk($sformatf("%s[%0d].core_x", tag, i), core_x, xv[tbl[i].g]);
      if (tbl[i].e_rsp != 2'b00) chk($sformatf("%s[%0d].rsp_y", tag, i), rsp_y, xv[tbl[i].g] ^ MASK);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    core_en = 1'b1; core_cnt = 0; core_done = 1'b0; core_y = '0;
    xv[0] = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    xv[1] = {32'hFFFF_8000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_1234};

    // Alternating grants with both requesters always valid: 0,1,0,1, five cycles each.
    tbl[0]  = mk(2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[1]  = mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
    tbl[2]  = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[3]  = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[4]  = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    tbl[5]  = mk(2'b11, 2'b11, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[6]  = mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
    tbl[7]  = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[8]  = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[9]  = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    tbl[10] = mk(2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[11] = mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
    tbl[12] = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[13] = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[14] = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    tbl[15] = mk(2'b11, 2'b11, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[16] = mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
    tbl[17] = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[18] = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[19] = mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    // Only requester 1 valid: three back-to-back grants to 1.
    tbl[20] = mk(2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[21] = mk(2'b10, 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
    tbl[22] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[23] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[24] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    tbl[25] = mk(2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[26] = mk(2'b10, 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
    tbl[27] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[28] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[29] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    tbl[30] = mk(2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[31] = mk(2'b10, 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1);
    tbl[32] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[33] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    tbl[34] = mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);

    // Reset state.
    do_reset();
    #1;
    chk_idle_zero("reset");

    // Single op from requester 0, end-to-end latency.
    step(2'b01, 2'b01);
    chk("t1.A.req_ready", VW'(req_ready), VW'(2'b01));
    step(2'b00, 2'b01);
    chk("t1.A1.core_start", VW'(core_start), VW'(1'b1));
    chk("t1.A1.core_x", core_x, xv[0]);
    step(2'b00, 2'b01);
    chk("t1.A2.core_start", VW'(core_start), VW'(1'b0));
    chk("t1.A2.core_x", core_x, xv[0]);
    step(2'b00, 2'b01);
    chk("t1.A3.rsp_valid", VW'(rsp_valid), VW'(2'b00));
    step(2'b00, 2'b01);
    chk("t1.A4.rsp_valid", VW'(rsp_valid), VW'(2'b01));
    chk("t1.A4.rsp_y", rsp_y, xv[0] ^ MASK);
    step(2'b00, 2'b01);
    chk("t1.A5.busy", VW'(busy), VW'(1'b0));
    chk("t1.A5.rsp_valid", VW'(rsp_valid), VW'(2'b00));

    // Table sequences.
    do_reset();
    run_rows(0, 19, "alt");
    do_reset();
    run_rows(20, 34, "r1only");

    // Response backpressure; rsp_ready of the other requester must not complete it.
    do_reset();
    step(2'b01, 2'b00);
    chk("t4.accept", VW'(req_ready), VW'(2'b01));
    step(2'b10, 2'b10);
    step(2'b10, 2'b10);
    step(2'b10, 2'b10);
    for (int k = 0; k < 6; k++) begin
      step(2'b10, 2'b10);
      chk($sformatf("t4.hold%0d.rsp_valid", k), VW'(rsp_valid), VW'(2'b01));
      chk($sformatf("t4.hold%0d.rsp_y", k), rsp_y, xv[0] ^ MASK);
      chk($sformatf("t4.hold%0d.req_ready", k), VW'(req_ready), VW'(2'b00));
      chk($sformatf("t4.hold%0d.core_start", k), VW'(core_start), VW'(1'b0));
    end
    step(2'b10, 2'b01);
    chk("t4.release.rsp_valid", VW'(rsp_valid), VW'(2'b01));
    step(2'b10, 2'b00);
    chk("t4.after.busy", VW'(busy), VW'(1'b0));
    chk("t4.after.req_ready", VW'(req_ready), VW'(2'b10));

    // Watchdog: the core never answers.
    do_reset();
    core_en = 1'b0;
    step(2'b01, 2'b11);
    chk("t5.accept", VW'(req_ready), VW'(2'b01));
    step(2'b11, 2'b11);
    chk("t5.core_start", VW'(core_start), VW'(1'b1));
    for (int k = 1; k <= 15; k++) begin
      step(2'b11, 2'b11);
      chk($sformatf("t5.S+%0d.err", k), VW'(err_timeout), VW'(k == 15));
      chk($sformatf("t5.S+%0d.rsp_valid", k), VW'(rsp_valid), VW'(2'b00));
      chk($sformatf("t5.S+%0d.busy", k), VW'(busy), VW'(1'b1));
    end
    step(2'b11, 2'b11);
    chk("t5.next.busy", VW'(busy), VW'(1'b0));
    chk("t5.next.err", VW'(err_timeout), VW'(1'b0));
    chk("t5.next.req_ready", VW'(req_ready), VW'(2'b10));
    core_en = 1'b1;

    // Reset while waiting on the core.
    do_reset();
    step(2'b01, 2'b11);
    chk("t6.accept", VW'(req_ready), VW'(2'b01));
    step(2'b00, 2'b11);
    step(2'b00, 2'b11);
    chk("t6.wait.busy", VW'(busy), VW'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_idle_zero("t6.rst");
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("t6.regrant", VW'(req_ready), VW'(2'b01));
    step(2'b10, 2'b11);
    chk("t6.regrant.core_x", core_x, xv[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
